// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - fixed-latency instruction fetch memory with flush and program-load port
// Optional macro IM_PARITY_EN adds per-word even parity and the IM_parityError output.
module instruction_memory #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     IM_ce,
    input  logic [ADDRESS_WIDTH-1:0] IM_address,
    input  logic                     IM_flush,
    output logic [DATA_WIDTH-1:0]    IM_data,
    output logic                     IM_dataValid,
    output logic [3:0]               IM_pending,
    input  logic                     load_en,
    input  logic [ADDRESS_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0]    load_data
`ifdef IM_PARITY_EN
    ,
    output logic                     IM_parityError
`endif
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int LAST  = LATENCY - 1;
`ifdef IM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [WORD_W-1:0]     rd_word;
    logic [WORD_W-1:0]     wr_word;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_d [LATENCY];
    logic [3:0]            pending_q, pending_d;
    logic [DATA_WIDTH-1:0] held_q;

    assign rd_word = mem_q[IM_address];
    assign rd_data = rd_word[DATA_WIDTH-1:0];

`ifdef IM_PARITY_EN
    assign wr_word = {^load_data, load_data};
`else
    assign wr_word = load_data;
`endif

    // Memory is never reset; the read above sees the pre-write word (read-before-write).
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_address] <= wr_word;
        end
    end

    // Data registers only advance with a live valid so the last stage keeps the delivered word.
    always_comb begin
        valid_d    = '0;
        pending_d  = '0;
        valid_d[0] = IM_ce;
        data_d[0]  = IM_ce ? rd_data : data_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1] & ~IM_flush;
            data_d[i]  = valid_d[i] ? data_q[i-1] : data_q[i];
        end
        for (int i = 0; i < LATENCY; i++) begin
            pending_d = pending_d + {3'b000, valid_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            pending_q <= '0;
            held_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            if (IM_dataValid) begin
                held_q <= data_q[LAST];
            end
        end
    end

    // A flush in the delivery cycle also suppresses the word already sitting at the output.
    assign IM_dataValid = valid_q[LAST] & ~IM_flush;
    assign IM_data      = IM_dataValid ? data_q[LAST] : held_q;
    assign IM_pending   = pending_q;

`ifdef IM_PARITY_EN
    logic [LATENCY-1:0] perr_q, perr_d;

    always_comb begin
        perr_d    = perr_q;
        perr_d[0] = IM_ce ? ^rd_word : perr_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            perr_d[i] = valid_d[i] ? perr_q[i-1] : perr_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign IM_parityError = IM_dataValid & perr_q[LAST];
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory (IM_PARITY_EN optional)
module tb_instruction_memory;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IM_ce;
    logic [2:0] IM_address;
    logic       IM_flush;
    logic [7:0] IM_data;
    logic       IM_dataValid;
    logic [3:0] IM_pending;
    logic       load_en;
    logic [2:0] load_address;
    logic [7:0] load_data;
`ifdef IM_PARITY_EN
    logic       IM_parityError;
`endif

    instruction_memory #(.ADDRESS_WIDTH(3), .DATA_WIDTH(8), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IM_ce        (IM_ce),
        .IM_address   (IM_address),
        .IM_flush     (IM_flush),
        .IM_data      (IM_data),
        .IM_dataValid (IM_dataValid),
        .IM_pending   (IM_pending),
        .load_en      (load_en),
        .load_address (load_address),
        .load_data    (load_data)
`ifdef IM_PARITY_EN
        ,
        .IM_parityError (IM_parityError)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       perr;
    } resp_t;

    resp_t      q[$];
    logic [7:0] mem_m [8];
    logic       bad [8];
    logic [7:0] last_data;
    int         cyc;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: each accepted request is due LATENCY cycles later; a flush drops everything queued.
    task automatic step(input logic ce, input logic [2:0] a, input logic fl,
                        input logic le, input logic [2:0] la, input logic [7:0] ld);
        int         pend;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_p;
        IM_ce        = ce;
        IM_address   = a;
        IM_flush     = fl;
        load_en      = le;
        load_address = la;
        load_data    = ld;
        @(negedge clk);
        pend = q.size();
        if (fl) q.delete();
        exp_v = 1'b0;
        exp_d = last_data;
        exp_p = 1'b0;
        if (q.size() > 0) begin
            if (q[0].due == cyc) begin
                exp_v = 1'b1;
                exp_d = q[0].data;
                exp_p = q[0].perr;
            end
        end
        chk("valid", {31'd0, IM_dataValid}, {31'd0, exp_v});
        chk("data", {24'd0, IM_data}, {24'd0, exp_d});
        chk("pending", {28'd0, IM_pending}, pend);
`ifdef IM_PARITY_EN
        chk("parity_error", {31'd0, IM_parityError}, {31'd0, exp_p});
`endif
        if (exp_v) begin
            last_data = exp_d;
            void'(q.pop_front());
        end
        if (ce) q.push_back('{cyc + LAT, mem_m[a], bad[a]});
        if (le) begin
            mem_m[la] = ld;
            bad[la]   = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, a, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic mid_reset();
        IM_ce   = 1'b0;
        IM_flush = 1'b0;
        load_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, IM_dataValid}, 32'd0);
        chk("rst_pending", {28'd0, IM_pending}, 32'd0);
        chk("rst_data", {24'd0, IM_data}, 32'd0);
        q.delete();
        last_data = 8'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_valid", {31'd0, IM_dataValid}, 32'd0);
            chk("rst_hold_pending", {28'd0, IM_pending}, 32'd0);
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        last_data = 8'd0;
        for (int i = 0; i < 8; i++) bad[i] = 1'b0;
        rst_n = 1'b0;
        IM_ce = 1'b0;
        IM_address = 3'd0;
        IM_flush = 1'b0;
        load_en = 1'b0;
        load_address = 3'd0;
        load_data = 8'd0;
        #3;
        chk("reset_valid", {31'd0, IM_dataValid}, 32'd0);
        chk("reset_data", {24'd0, IM_data}, 32'd0);
        chk("reset_pending", {28'd0, IM_pending}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b1, 3'(i), 8'(8'h10 + i));
        end
        idle(2);

        // back-to-back reads
        rd(3'd0); rd(3'd1); rd(3'd2); idle(3);
        // bubble between reads
        rd(3'd3); idle(1); rd(3'd4); idle(3);
        // flush with redirect target in the same cycle
        rd(3'd0); rd(3'd1); step(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 8'd0); idle(3);
        // read-before-write, then re-read
        step(1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 8'hAA); rd(3'd2); idle(3);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 8'h12);
        // address wrap
        rd(3'd7); rd(3'd0); rd(3'd7); idle(3);
        // reset mid-operation, then accept in the first cycle after release
        rd(3'd1); rd(3'd5);
        mid_reset();
        rd(3'd3);
        for (int i = 0; i < 8; i++) rd(3'(i));
        idle(3);

        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, 3'($urandom % 8), ($urandom % 8) == 0,
                 ($urandom % 4) == 0, 3'($urandom % 8), 8'($urandom % 256));
            if (n == 200) begin
                mid_reset();
            end
        end
        idle(3);

`ifdef IM_PARITY_EN
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b1, 3'(i), 8'(8'h10 + i));
        end
        dut.mem_q[5][0] = ~dut.mem_q[5][0];
        mem_m[5] = mem_m[5] ^ 8'h01;
        bad[5] = 1'b1;
        rd(3'd5); rd(3'd4); idle(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
